// File: rtl/instruction_decode_stage_pkg.sv
// Opcode map, instruction classes, state encoding and field positions for the decode stage.
package opcodes;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } dec_state_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_HALT   = 8'hFF;
    localparam logic [7:0] ALU_LO    = 8'h01;
    localparam logic [7:0] ALU_HI    = 8'h3F;
    localparam logic [7:0] LOAD_LO   = 8'h40;
    localparam logic [7:0] LOAD_HI   = 8'h4F;
    localparam logic [7:0] STORE_LO  = 8'h50;
    localparam logic [7:0] STORE_HI  = 8'h5F;
    localparam logic [7:0] BRANCH_LO = 8'h60;
    localparam logic [7:0] BRANCH_HI = 8'h6F;

    localparam int OPC_LSB  = 24;
    localparam int RD_LSB   = 20;
    localparam int RS1_LSB  = 16;
    localparam int RS2_LSB  = 12;
    localparam int IMM_BITS = 12;

    function automatic instr_class_t classify(input logic [7:0] op);
        instr_class_t c;
        if (op == OP_NOP)
            c = CLS_NOP;
        else if (op >= ALU_LO && op <= ALU_HI)
            c = CLS_ALU;
        else if (op >= LOAD_LO && op <= LOAD_HI)
            c = CLS_LOAD;
        else if (op >= STORE_LO && op <= STORE_HI)
            c = CLS_STORE;
        else if (op >= BRANCH_LO && op <= BRANCH_HI)
            c = CLS_BRANCH;
        else if (op == OP_HALT)
            c = CLS_HALT;
        else
            c = CLS_ILLEGAL;
        return c;
    endfunction

endpackage

// File: rtl/instruction_decode_stage_field_decode.sv
// Splits one instruction word into its fields and classifies the opcode.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module instr_field_decode
    import opcodes::*;
#(
    parameter int width    = 32,
    parameter int reg_bits = 4
) (
    input  logic [width-1:0]    instruction,
    output logic [7:0]          opcode,
    output logic [reg_bits-1:0] rd,
    output logic [reg_bits-1:0] rs1,
    output logic [reg_bits-1:0] rs2,
    output logic [width-1:0]    imm,
    output instr_class_t        cls
);

    assign opcode = instruction[OPC_LSB +: 8];
    assign rd     = instruction[RD_LSB  +: reg_bits];
    assign rs1    = instruction[RS1_LSB +: reg_bits];
    assign rs2    = instruction[RS2_LSB +: reg_bits];
    assign imm    = {{(width-IMM_BITS){instruction[IMM_BITS-1]}}, instruction[IMM_BITS-1:0]};
    assign cls    = classify(opcode);

endmodule

// File: rtl/instruction_decode_stage.sv
// Decode stage: pulls words from the fetch FIFO, presents decoded fields; DECODE_ILLEGAL_TRAP_EN halts on ILLEGAL.
// Latency: fetch_lat+1 cycles from the next pulse to dec_valid; one instruction in flight or held at a time.
// Backpressure: dec_ready low holds all dec_* outputs stable and blocks further next pulses.
module instruction_decode_stage
    import opcodes::*;
#(
    parameter int width     = 32,
    parameter int reg_bits  = 4,
    parameter int fetch_lat = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_empty,
    input  logic [width-1:0]    instruction,
    output logic                next,
    output logic                fetch_stop,
    input  logic                flush,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [7:0]          dec_opcode,
    output logic [reg_bits-1:0] dec_rd,
    output logic [reg_bits-1:0] dec_rs1,
    output logic [reg_bits-1:0] dec_rs2,
    output logic [width-1:0]    dec_imm,
    output logic [2:0]          dec_class
);

    localparam logic [2:0] LAT_INIT = 3'(fetch_lat);

    dec_state_t   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         discard_q, discard_d;
    logic         valid_q, valid_d;
    logic         stop_q, stop_d;
    logic         issue, capture, trap;

    logic [7:0]          f_opcode;
    logic [reg_bits-1:0] f_rd, f_rs1, f_rs2;
    logic [width-1:0]    f_imm;
    instr_class_t        f_class, class_q;

    instr_field_decode #(
        .width    (width),
        .reg_bits (reg_bits)
    ) u_fields (
        .instruction (instruction),
        .opcode      (f_opcode),
        .rd          (f_rd),
        .rs1         (f_rs1),
        .rs2         (f_rs2),
        .imm         (f_imm),
        .cls         (f_class)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign trap = (f_class == CLS_HALT) || (f_class == CLS_ILLEGAL);
`else
    assign trap = (f_class == CLS_HALT);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        valid_d   = valid_q;
        stop_d    = stop_q;
        issue     = 1'b0;
        capture   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fetch_empty && !valid_q && !flush)
                    issue = 1'b1;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    // The requested word is on the bus this cycle; a flush seen at any point drops it.
                    discard_d = 1'b0;
                    if (discard_q || flush) begin
                        state_d = S_IDLE;
                    end else begin
                        capture = 1'b1;
                        valid_d = 1'b1;
                        if (trap) begin
                            state_d = S_HALTED;
                            stop_d  = 1'b1;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (valid_q && dec_ready) begin
                    valid_d = 1'b0;
                    if (!fetch_empty)
                        issue = 1'b1;
                    else
                        state_d = S_IDLE;
                end
            end
            S_HALTED: begin
                if (flush)
                    state_d = S_IDLE;
                else if (valid_q && dec_ready)
                    valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
        end
        if (flush) begin
            valid_d = 1'b0;
            stop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            discard_q <= 1'b0;
            valid_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            valid_q   <= valid_d;
            stop_q    <= stop_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_opcode <= '0;
            dec_rd     <= '0;
            dec_rs1    <= '0;
            dec_rs2    <= '0;
            dec_imm    <= '0;
            class_q    <= CLS_NOP;
        end else if (capture) begin
            dec_opcode <= f_opcode;
            dec_rd     <= f_rd;
            dec_rs1    <= f_rs1;
            dec_rs2    <= f_rs2;
            dec_imm    <= f_imm;
            class_q    <= f_class;
        end
    end

    // Reset must hold next low even though the idle state would otherwise request a word.
    assign next       = issue & rst;
    assign dec_valid  = valid_q;
    assign fetch_stop = stop_q;
    assign dec_class  = class_q;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;
    import opcodes::*;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_empty = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        next, fetch_stop, dec_valid;
    logic        flush = 1'b0;
    logic        dec_ready = 1'b0;
    logic [7:0]  dec_opcode;
    logic [3:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm;
    logic [2:0]  dec_class;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    instruction_decode_stage #(.width(32), .reg_bits(4), .fetch_lat(L)) dut (
        .clk(clk), .rst(rst), .fetch_empty(fetch_empty), .instruction(instruction),
        .next(next), .fetch_stop(fetch_stop), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_imm(dec_imm), .dec_class(dec_class)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  cls;
    } dec_t;

    typedef struct packed {
        logic [31:0] word;
        dec_t        exp;
    } vec_t;

    // fetch FIFO contents and words already requested but not yet on the bus
    logic [31:0] src_q[$];
    logic [31:0] pipe_w[$];
    int          pipe_due[$];
    int          cyc = 0;
    bit          want_ready = 1'b0, want_flush = 1'b0;

    // reference model: one pending request, one held instruction, halted flag
    bit          m_pend = 0, m_disc = 0, m_held = 0, m_halt = 0;
    int          m_arrive = 0;
    logic [31:0] m_pword = 0, m_hword = 0;

    bit   obs_next, obs_valid, obs_accept;
    dec_t obs_dec;
    int   last_next_cyc = 0, last_acc_cyc = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        int   op;
        op    = int'(w >> 24);
        d.op  = w[31:24];
        d.rd  = w[23:20];
        d.rs1 = w[19:16];
        d.rs2 = w[15:12];
        d.imm = (w[11] ? 32'hFFFF_F000 : 32'h0) | (w & 32'h0000_0FFF);
        if (op == 0)         d.cls = CLS_NOP;
        else if (op < 'h40)  d.cls = CLS_ALU;
        else if (op < 'h50)  d.cls = CLS_LOAD;
        else if (op < 'h60)  d.cls = CLS_STORE;
        else if (op < 'h70)  d.cls = CLS_BRANCH;
        else if (op == 'hFF) d.cls = CLS_HALT;
        else                 d.cls = CLS_ILLEGAL;
        return d;
    endfunction

    function automatic bit stops_fetch(input logic [2:0] cls);
`ifdef DECODE_ILLEGAL_TRAP_EN
        return (cls == CLS_HALT) || (cls == CLS_ILLEGAL);
`else
        return cls == CLS_HALT;
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0] op;
        case ($urandom_range(0, 7))
            0:       op = 8'h00;
            1:       op = 8'($urandom_range(8'h01, 8'h3F));
            2:       op = 8'($urandom_range(8'h40, 8'h4F));
            3:       op = 8'($urandom_range(8'h50, 8'h5F));
            4:       op = 8'($urandom_range(8'h60, 8'h6F));
            5:       op = 8'hFF;
            6:       op = 8'($urandom_range(8'h70, 8'hFE));
            default: op = 8'($urandom);
        endcase
        return {op, 24'($urandom)};
    endfunction

    // One clock cycle: drive inputs just after the edge, observe and check at the falling edge.
    task automatic tick();
        dec_t        e;
        bit          exp_next;
        logic [31:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (pipe_due.size() != 0 && pipe_due[0] == cyc) begin
            instruction = pipe_w.pop_front();
            void'(pipe_due.pop_front());
        end else begin
            instruction = $urandom;
        end
        fetch_empty = (src_q.size() == 0);
        dec_ready   = want_ready;
        flush       = want_flush;
        @(negedge clk);

        exp_next = !fetch_empty && !flush && !m_halt && !m_pend && (!m_held || dec_ready);
        check1("next", next, exp_next);
        check1("dec_valid", dec_valid, m_held);
        check1("fetch_stop", fetch_stop, m_halt);
        if (m_held) begin
            e = ref_decode(m_hword);
            check32("dec_opcode", 32'(dec_opcode), 32'(e.op));
            check32("dec_rd", 32'(dec_rd), 32'(e.rd));
            check32("dec_rs1", 32'(dec_rs1), 32'(e.rs1));
            check32("dec_rs2", 32'(dec_rs2), 32'(e.rs2));
            check32("dec_imm", dec_imm, e.imm);
            check32("dec_class", 32'(dec_class), 32'(e.cls));
        end

        obs_next   = next;
        obs_valid  = dec_valid;
        obs_accept = dec_valid && dec_ready && !flush;
        obs_dec    = '{dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_class};
        if (obs_next)   last_next_cyc = cyc;
        if (obs_accept) last_acc_cyc  = cyc;

        if (flush) begin
            m_held = 0;
            m_halt = 0;
            if (m_pend) m_disc = 1;
        end else if (m_held && dec_ready) begin
            m_held = 0;
        end
        if (m_pend && cyc == m_arrive) begin
            m_pend = 0;
            if (!m_disc) begin
                m_held  = 1;
                m_hword = m_pword;
                if (stops_fetch(ref_decode(m_pword).cls)) m_halt = 1;
            end
        end
        if (next && src_q.size() != 0) begin
            w = src_q.pop_front();
            pipe_w.push_back(w);
            pipe_due.push_back(cyc + L);
            m_pend   = 1;
            m_disc   = 0;
            m_arrive = cyc + L;
            m_pword  = w;
        end
    endtask

    // which: 0 = next pulse, 1 = dec_valid, 2 = accepted handshake
    task automatic wait_ev(input int which, input int maxc, output bit ok);
        ok = 0;
        for (int k = 0; k < maxc && !ok; k++) begin
            tick();
            case (which)
                0:       ok = obs_next;
                1:       ok = obs_valid;
                default: ok = obs_accept;
            endcase
        end
        check1("wait_event", ok, 1'b1);
    endtask

    task automatic reset_mid_cycle(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check1({tag, "_next"}, next, 1'b0);
        check1({tag, "_valid"}, dec_valid, 1'b0);
        check1({tag, "_stop"}, fetch_stop, 1'b0);
        check32({tag, "_op"}, 32'(dec_opcode), 32'h0);
        check32({tag, "_imm"}, dec_imm, 32'h0);
        src_q.delete();
        pipe_w.delete();
        pipe_due.delete();
        m_pend = 0; m_disc = 0; m_held = 0; m_halt = 0;
        want_flush  = 1'b0;
        flush       = 1'b0;
        fetch_empty = 1'b0;
        @(negedge clk);
        check1({tag, "_next_held"}, next, 1'b0);
        rst = 1'b1;
        fetch_empty = 1'b1;
    endtask

    initial begin
        vec_t       tbl[9];
        bit         ok;
        int         nx, nv, n, a;
        int         ncyc[3];
        logic [2:0] acls[3];

        tbl[0] = '{32'h0512_3FFE, '{8'h05, 4'h1, 4'h2, 4'h3, 32'hFFFF_FFFE, CLS_ALU}};
        tbl[1] = '{32'h4000_07FF, '{8'h40, 4'h0, 4'h0, 4'h0, 32'h0000_07FF, CLS_LOAD}};
        tbl[2] = '{32'h6ABC_D800, '{8'h6A, 4'hB, 4'hC, 4'hD, 32'hFFFF_F800, CLS_BRANCH}};
        tbl[3] = '{32'h5F98_7123, '{8'h5F, 4'h9, 4'h8, 4'h7, 32'h0000_0123, CLS_STORE}};
        tbl[4] = '{32'h0000_0000, '{8'h00, 4'h0, 4'h0, 4'h0, 32'h0000_0000, CLS_NOP}};
        tbl[5] = '{32'h3F21_0FFF, '{8'h3F, 4'h2, 4'h1, 4'h0, 32'hFFFF_FFFF, CLS_ALU}};
        tbl[6] = '{32'h4F00_0001, '{8'h4F, 4'h0, 4'h0, 4'h0, 32'h0000_0001, CLS_LOAD}};
        tbl[7] = '{32'h6F00_0000, '{8'h6F, 4'h0, 4'h0, 4'h0, 32'h0000_0000, CLS_BRANCH}};
        tbl[8] = '{32'h5000_0800, '{8'h50, 4'h0, 4'h0, 4'h0, 32'hFFFF_F800, CLS_STORE}};

        // reset state with work waiting in the FIFO
        @(negedge clk);
        @(negedge clk);
        check1("rst_next", next, 1'b0);
        check1("rst_valid", dec_valid, 1'b0);
        check1("rst_stop", fetch_stop, 1'b0);
        check32("rst_fields", {dec_opcode, dec_rd, dec_rs1, dec_rs2, 12'h0}, 32'h0);
        check32("rst_imm", dec_imm, 32'h0);
        check32("rst_class", 32'(dec_class), 32'h0);
        rst = 1'b1;
        fetch_empty = 1'b1;

        // table of words, dec_ready tied high
        want_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            src_q.push_back(tbl[i].word);
            wait_ev(2, 20, ok);
            check32($sformatf("t%0d_latency", i), 32'(last_acc_cyc - last_next_cyc), 32'(L + 1));
            check32($sformatf("t%0d_op", i), 32'(obs_dec.op), 32'(tbl[i].exp.op));
            check32($sformatf("t%0d_regs", i), 32'({obs_dec.rd, obs_dec.rs1, obs_dec.rs2}),
                    32'({tbl[i].exp.rd, tbl[i].exp.rs1, tbl[i].exp.rs2}));
            check32($sformatf("t%0d_imm", i), obs_dec.imm, tbl[i].exp.imm);
            check32($sformatf("t%0d_class", i), 32'(obs_dec.cls), 32'(tbl[i].exp.cls));
        end

        // stall: held for 5 cycles with another word waiting
        want_ready = 1'b0;
        src_q.push_back(32'h4000_07FF);
        src_q.push_back(32'h0100_0000);
        wait_ev(1, 20, ok);
        nx = 0;
        repeat (5) begin
            tick();
            nx += int'(obs_next);
        end
        check32("stall_no_next", 32'(nx), 32'h0);
        check32("stall_class", 32'(dec_class), 32'(CLS_LOAD));
        check32("stall_imm", dec_imm, 32'h0000_07FF);
        want_ready = 1'b1;
        wait_ev(2, 20, ok);
        wait_ev(2, 20, ok);

        // back-to-back throughput
        src_q.push_back(32'h6123_4567);
        src_q.push_back(32'h5123_4567);
        src_q.push_back(32'h0012_3456);
        n = 0;
        a = 0;
        for (int k = 0; k < 30 && a < 3; k++) begin
            tick();
            if (obs_next && n < 3) begin ncyc[n] = cyc; n++; end
            if (obs_accept) begin acls[a] = obs_dec.cls; a++; end
        end
        check32("tp_accepts", 32'(a), 32'd3);
        check32("tp_gap1", 32'(ncyc[1] - ncyc[0]), 32'(L + 1));
        check32("tp_gap2", 32'(ncyc[2] - ncyc[1]), 32'(L + 1));
        check32("tp_cls0", 32'(acls[0]), 32'(CLS_BRANCH));
        check32("tp_cls1", 32'(acls[1]), 32'(CLS_STORE));
        check32("tp_cls2", 32'(acls[2]), 32'(CLS_NOP));

        // HALT holds fetch idle until flush
        src_q.push_back(32'hFF00_0000);
        src_q.push_back(32'h0100_0000);
        wait_ev(2, 20, ok);
        check32("halt_class", 32'(obs_dec.cls), 32'(CLS_HALT));
        nx = 0;
        repeat (20) begin
            tick();
            nx += int'(obs_next);
        end
        check32("halt_no_next", 32'(nx), 32'h0);
        check1("halt_stop", fetch_stop, 1'b1);
        want_flush = 1'b1;
        tick();
        want_flush = 1'b0;
        tick();
        check1("halt_stop_clr", fetch_stop, 1'b0);
        wait_ev(2, 20, ok);
        check32("halt_resume_op", 32'(obs_dec.op), 32'h01);

        // flush one cycle after next drops the in-flight word
        src_q.push_back(32'h1111_1111);
        wait_ev(0, 20, ok);
        want_flush = 1'b1;
        tick();
        want_flush = 1'b0;
        nv = 0;
        repeat (L + 3) begin
            tick();
            nv += int'(obs_valid);
        end
        check32("flush_discard", 32'(nv), 32'h0);
        src_q.push_back(32'h2200_0000);
        wait_ev(2, 20, ok);
        check32("flush_resume_op", 32'(obs_dec.op), 32'h22);

        // ILLEGAL opcode
        src_q.push_back(32'h7A00_0000);
        src_q.push_back(32'h0300_0000);
        wait_ev(2, 20, ok);
        check32("ill_class", 32'(obs_dec.cls), 32'(CLS_ILLEGAL));
`ifdef DECODE_ILLEGAL_TRAP_EN
        nx = 0;
        repeat (10) begin
            tick();
            nx += int'(obs_next);
        end
        check32("ill_no_next", 32'(nx), 32'h0);
        check1("ill_stop", fetch_stop, 1'b1);
        want_flush = 1'b1;
        tick();
        want_flush = 1'b0;
`endif
        wait_ev(2, 20, ok);
        check32("ill_follow_op", 32'(obs_dec.op), 32'h03);

        // asynchronous reset mid-wait and while a HALT is presented
        src_q.push_back(32'h0A00_0000);
        wait_ev(0, 20, ok);
        reset_mid_cycle("rst_wait");
        want_ready = 1'b0;
        src_q.push_back(32'hFF00_0000);
        wait_ev(1, 20, ok);
        check1("pre_rst_stop", fetch_stop, 1'b1);
        reset_mid_cycle("rst_halt");

        // randomized traffic against the reference model
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 3) == 0 && src_q.size() < 4) src_q.push_back(rand_word());
            want_ready = ($urandom_range(0, 3) != 0);
            want_flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        want_flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
